matrix_loader: RTL



---
 rtl/mm_pkg.sv | 37 +++
 rtl/bank_scatter.sv | 55 +++++
 rtl/matrix_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// -----------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the matrix multiplier front-end and its controller.
//   mm_state_t  : loader FSM state encoding
//   clog2_min1  : $clog2 that never returns 0, so degenerate sizes still give
//                 a legal 1-bit vector
//   a_aw / b_aw : address widths of one A bank / one B bank
//   A_AW / B_AW : those widths for the default 3x3x3, 3-bank configuration
// -----------------------------------------------------------------------------
package mm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_A  = 3'd1,
        ST_LOAD_B  = 3'd2,
        ST_RUN     = 3'd3,
        ST_RELEASE = 3'd4
    } mm_state_t;

    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    // Each A bank holds M/N_BANKS rows of K elements.
    function automatic int a_aw(input int m, input int k, input int n_banks);
        return clog2_min1(m / n_banks * k);
    endfunction

    // Each B bank holds K rows of N/N_BANKS columns.
    function automatic int b_aw(input int k, input int n, input int n_banks);
        return clog2_min1(k * n / n_banks);
    endfunction

    localparam int A_AW = a_aw(3, 3, 3);
    localparam int B_AW = b_aw(3, 3, 3);

endpackage

// File: rtl/bank_scatter.sv
// -----------------------------------------------------------------------------
// bank_scatter
// Registers one element write into a set of banked BRAMs: a one-hot strobe for
// the selected bank, that bank's address inserted into its slice of the packed
// address bus (all other slices 0), and the shared write data.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   wr_en         : write this cycle
//   bank          : target bank index
//   addr          : address within the target bank
//   din           : element value
//   we            : registered one-hot strobe, high for one cycle per write
//   addr_packed   : registered packed addresses, bank b in slice b
//   dout          : registered write data (holds between writes)
// -----------------------------------------------------------------------------
module bank_scatter #(
    parameter int DATA_WIDTH = 16,
    parameter int N_BANKS    = 3,
    parameter int AW         = 2,
    parameter int BW         = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [BW-1:0]           bank,
    input  logic [AW-1:0]           addr,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [N_BANKS-1:0]      we,
    output logic [N_BANKS*AW-1:0]   addr_packed,
    output logic [DATA_WIDTH-1:0]   dout
);

    logic [N_BANKS-1:0]    we_next;
    logic [N_BANKS*AW-1:0] addr_next;

    for (genvar gi = 0; gi < N_BANKS; gi++) begin : g_bank
        assign we_next[gi]               = wr_en && (bank == BW'(gi));
        assign addr_next[gi*AW +: AW]    = we_next[gi] ? addr : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we          <= '0;
            addr_packed <= '0;
            dout        <= '0;
        end else begin
            we          <= we_next;
            addr_packed <= addr_next;
            if (wr_en) begin
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
// Streaming front-end for the matrix multiplier. Accepts A (MxK, row-major)
// then B (KxN, row-major) as one valid/ready stream, scatters each element into
// the banked A/B BRAMs, then holds mm_start until the controller finishes.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   load_start                 : begin a new load (only honoured in IDLE)
//   s_valid/s_ready/s_data     : element stream; s_last marks the final B element
//   we_a_brams/addr_a_brams/din_a : A bank writes (bank = m % N_BANKS)
//   we_b_brams/addr_b_brams/din_b : B bank writes (bank = n % N_BANKS)
//   mm_start / mm_done         : level handshake with the multiply controller
//   busy                       : any state other than IDLE
//   load_done                  : one-cycle pulse after a completed run
//   frame_err                  : sticky framing error, cleared by load_start
// -----------------------------------------------------------------------------
module matrix_loader
    import mm_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 3,
    parameter int K          = 3,
    parameter int N          = 3,
    parameter int N_BANKS    = 3,
    localparam int AW_A      = a_aw(M, K, N_BANKS),
    localparam int AW_B      = b_aw(K, N, N_BANKS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_start,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_last,
    output logic [N_BANKS-1:0]          we_a_brams,
    output logic [N_BANKS*AW_A-1:0]     addr_a_brams,
    output logic [DATA_WIDTH-1:0]       din_a,
    output logic [N_BANKS-1:0]          we_b_brams,
    output logic [N_BANKS*AW_B-1:0]     addr_b_brams,
    output logic [DATA_WIDTH-1:0]       din_b,
    output logic                        mm_start,
    input  logic                        mm_done,
    output logic                        busy,
    output logic                        load_done,
    output logic                        frame_err
);

    localparam int MW = clog2_min1(M);
    localparam int KW = clog2_min1(K);
    localparam int NW = clog2_min1(N);
    localparam int BW = clog2_min1(N_BANKS);
    localparam int CW = clog2_min1(N / N_BANKS);

    mm_state_t         state_reg;

    // A position: (m,k) plus the bank and the row-group base (m/N_BANKS)*K,
    // both tracked incrementally so no division is needed.
    logic [MW-1:0]     a_m_reg;
    logic [KW-1:0]     a_k_reg;
    logic [BW-1:0]     a_bank_reg;
    logic [AW_A-1:0]   a_base_reg;

    // B position: (k,n) plus bank = n%N_BANKS, column-in-bank n/N_BANKS and
    // row base k*(N/N_BANKS).
    logic [KW-1:0]     b_k_reg;
    logic [NW-1:0]     b_n_reg;
    logic [BW-1:0]     b_bank_reg;
    logic [CW-1:0]     b_col_reg;
    logic [AW_B-1:0]   b_base_reg;

    logic              frame_err_reg;
    logic              load_done_reg;

    logic              accept;
    logic              a_row_end, a_last, b_row_end, b_last;

    assign s_ready   = (state_reg == ST_LOAD_A) || (state_reg == ST_LOAD_B);
    assign busy      = (state_reg != ST_IDLE);
    assign mm_start  = (state_reg == ST_RUN);
    assign load_done = load_done_reg;
    assign frame_err = frame_err_reg;

    assign accept    = s_valid && s_ready;
    assign a_row_end = (a_k_reg == KW'(K - 1));
    assign a_last    = a_row_end && (a_m_reg == MW'(M - 1));
    assign b_row_end = (b_n_reg == NW'(N - 1));
    assign b_last    = b_row_end && (b_k_reg == KW'(K - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            a_m_reg       <= '0;
            a_k_reg       <= '0;
            a_bank_reg    <= '0;
            a_base_reg    <= '0;
            b_k_reg       <= '0;
            b_n_reg       <= '0;
            b_bank_reg    <= '0;
            b_col_reg     <= '0;
            b_base_reg    <= '0;
            frame_err_reg <= 1'b0;
            load_done_reg <= 1'b0;
        end else begin
            load_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (load_start) begin
                        state_reg     <= ST_LOAD_A;
                        frame_err_reg <= 1'b0;
                        a_m_reg       <= '0;
                        a_k_reg       <= '0;
                        a_bank_reg    <= '0;
                        a_base_reg    <= '0;
                        b_k_reg       <= '0;
                        b_n_reg       <= '0;
                        b_bank_reg    <= '0;
                        b_col_reg     <= '0;
                        b_base_reg    <= '0;
                    end
                end
                ST_LOAD_A: begin
                    if (accept) begin
                        // s_last can never be legal inside A, even on its last element.
                        if (s_last) begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end else if (a_last) begin
                            state_reg <= ST_LOAD_B;
                        end
                        if (a_row_end) begin
                            a_k_reg <= '0;
                            a_m_reg <= a_m_reg + 1'b1;
                            if (a_bank_reg == BW'(N_BANKS - 1)) begin
                                a_bank_reg <= '0;
                                a_base_reg <= a_base_reg + AW_A'(K);
                            end else begin
                                a_bank_reg <= a_bank_reg + 1'b1;
                            end
                        end else begin
                            a_k_reg <= a_k_reg + 1'b1;
                        end
                    end
                end
                ST_LOAD_B: begin
                    if (accept) begin
                        if (b_last) begin
                            // A missing s_last is flagged but the run still starts.
                            state_reg <= ST_RUN;
                            if (!s_last) begin
                                frame_err_reg <= 1'b1;
                            end
                        end else if (s_last) begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= ST_IDLE;
                        end
                        if (b_row_end) begin
                            b_n_reg    <= '0;
                            b_bank_reg <= '0;
                            b_col_reg  <= '0;
                            b_k_reg    <= b_k_reg + 1'b1;
                            b_base_reg <= b_base_reg + AW_B'(N / N_BANKS);
                        end else begin
                            b_n_reg <= b_n_reg + 1'b1;
                            if (b_bank_reg == BW'(N_BANKS - 1)) begin
                                b_bank_reg <= '0;
                                b_col_reg  <= b_col_reg + 1'b1;
                            end else begin
                                b_bank_reg <= b_bank_reg + 1'b1;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (mm_done) begin
                        state_reg <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!mm_done) begin
                        state_reg     <= ST_IDLE;
                        load_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    bank_scatter #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_BANKS    (N_BANKS),
        .AW         (AW_A),
        .BW         (BW)
    ) u_scatter_a (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (accept && (state_reg == ST_LOAD_A)),
        .bank        (a_bank_reg),
        .addr        (a_base_reg + AW_A'(a_k_reg)),
        .din         (s_data),
        .we          (we_a_brams),
        .addr_packed (addr_a_brams),
        .dout        (din_a)
    );

    bank_scatter #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_BANKS    (N_BANKS),
        .AW         (AW_B),
        .BW         (BW)
    ) u_scatter_b (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (accept && (state_reg == ST_LOAD_B)),
        .bank        (b_bank_reg),
        .addr        (b_base_reg + AW_B'(b_col_reg)),
        .din         (s_data),
        .we          (we_b_brams),
        .addr_packed (addr_b_brams),
        .dout        (din_b)
    );

endmodule
